// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter.
// Grant encoding, response FSM states and streak counter width.
package mem_arb_pkg;

    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IF_RSP,
        ARB_D_RSP
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_D
    } grant_t;

endpackage

// File: rtl/arb_fairness_ctr.sv
// Fairness streak counter for the unified memory arbiter.
// Counts D grants taken while IF waits; force_if hands the next slot to IF.
module arb_fairness_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    input  logic d_gnt,
    output logic force_if
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] streak;

    // Streak grows per D grant while IF waits, saturating; IF service or no IF demand clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (if_gnt || !if_req) begin
            streak <= '0;
        end else if (d_gnt && (streak != STREAK_MAX)) begin
            streak <= streak + 1'b1;
        end
    end

    assign force_if = (streak == STREAK_MAX);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between fetch (IF) and load/store (D).
// Optional ARB_PERF_EN adds conflict and IF-stall performance counters.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_conflict_cnt,
    output logic [31:0]       perf_if_stall_cnt
`endif
);

    grant_t     grant;
    arb_state_t state_q;
    arb_state_t state_d;
    logic       force_if;

    arb_fairness_ctr #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_fair (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .d_gnt   (d_gnt),
        .force_if(force_if)
    );

    // Pick the single requester for this cycle: D first unless IF has waited too long
    always_comb begin
        grant = GNT_NONE;
        if (!reset) begin
            if (d_req && !(if_req && force_if)) begin
                grant = GNT_D;
            end else if (if_req) begin
                grant = GNT_IF;
            end
        end
    end

    // Drive grants, stalls and the memory port from the chosen grant
    always_comb begin
        if_gnt    = (grant == GNT_IF);
        d_gnt     = (grant == GNT_D);
        if_stall  = if_req & ~if_gnt;
        d_stall   = d_req & ~d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = d_gnt ? d_addr : if_addr;
        mem_wdata = d_wdata;
    end

    // Response state register remembering which read was granted last cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next response state and the one-cycle rvalid pulses; reset drops a pending response
    always_comb begin
        state_d   = ARB_IDLE;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        unique case (grant)
            GNT_IF:   state_d = ARB_IF_RSP;
            GNT_D:    state_d = d_we ? ARB_IDLE : ARB_D_RSP;
            default:  state_d = ARB_IDLE;
        endcase
        if (!reset) begin
            if_rvalid = (state_q == ARB_IF_RSP);
            d_rvalid  = (state_q == ARB_D_RSP);
        end
    end

    // Capture read data only for the requester that owned the read
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if (grant == GNT_IF) begin
                if_rdata <= mem_rdata;
            end
            if ((grant == GNT_D) && !d_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_EN
    // Free-running performance counters, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_conflict_cnt <= '0;
            perf_if_stall_cnt <= '0;
        end else begin
            if (if_req && d_req) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (if_stall) begin
                perf_if_stall_cnt <= perf_if_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed steps plus random traffic.
// A transaction-level reference model predicts grants, responses and memory contents.
module tb_unified_mem_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef ARB_PERF_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_if_stall_cnt;
`endif

    unified_mem_arbiter #(
        .MAX_D_STREAK(MAXS),
        .ADDR_W      (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_stall  (d_stall),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
        ,
        .perf_conflict_cnt(perf_conflict_cnt),
        .perf_if_stall_cnt(perf_if_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory environment: 64 words, word-selected by address bits [7:2]
    logic [31:0] bmem [64];
    assign mem_rdata = bmem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) bmem[mem_addr[7:2]] <= mem_wdata;
    end

    // Reference model state
    logic [31:0] ref_mem [64];
    int          m_streak;
    bit          m_if_rv;
    bit          m_d_rv;
    logic [31:0] m_if_rd;
    logic [31:0] m_d_rd;
    bit          last_gi;
    bit          last_gd;

    // Observed values of the most recent step
    logic        o_if_gnt;
    logic        o_d_gnt;
    logic        o_if_stall;
    logic        o_d_rvalid;
    logic        o_mem_we;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_streak = 0;
        m_if_rv  = 0;
        m_d_rv   = 0;
        m_if_rd  = '0;
        m_d_rd   = '0;
    endtask

    // One clock cycle: inputs already driven; check at negedge, advance model
    task automatic step();
        bit gi;
        bit gd;
        logic [31:0] ea;
        @(negedge clk);
        gi = 0;
        gd = 0;
        if (!reset) begin
            if (d_req && !(if_req && m_streak == MAXS)) gd = 1;
            else if (if_req) gi = 1;
        end
        ea = gd ? d_addr : if_addr;
        o_if_gnt   = if_gnt;
        o_d_gnt    = d_gnt;
        o_if_stall = if_stall;
        o_d_rvalid = d_rvalid;
        o_mem_we   = mem_we;
        chk("if_gnt", {31'b0, if_gnt}, {31'b0, gi});
        chk("d_gnt", {31'b0, d_gnt}, {31'b0, gd});
        chk("mem_we", {31'b0, mem_we}, {31'b0, gd & d_we});
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, d_wdata);
        chk("if_stall", {31'b0, if_stall}, {31'b0, if_req & ~gi});
        chk("d_stall", {31'b0, d_stall}, {31'b0, d_req & ~gd});
        chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, m_if_rv & ~reset});
        chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, m_d_rv & ~reset});
        chk("if_rdata", if_rdata, m_if_rd);
        chk("d_rdata", d_rdata, m_d_rd);
        if (reset) begin
            model_reset();
        end else begin
            m_if_rv = gi;
            m_d_rv  = gd && !d_we;
            if (gi) m_if_rd = ref_mem[if_addr[7:2]];
            if (gd && !d_we) m_d_rd = ref_mem[d_addr[7:2]];
            if (gd && d_we) ref_mem[d_addr[7:2]] = d_wdata;
            if (gi || !if_req) m_streak = 0;
            else if (gd && m_streak < MAXS) m_streak++;
        end
        last_gi = gi;
        last_gd = gd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stalls;
        int ifg;
        bit first_d;
        for (int i = 0; i < 64; i++) begin
            bmem[i]    = $urandom;
            ref_mem[i] = bmem[i];
        end
        bmem[0]    = 32'hEF200005;
        ref_mem[0] = 32'hEF200005;
        model_reset();

        // Test 1: reset held with both requests, then first grant is D
        reset   = 1;
        if_req  = 1;
        d_req   = 1;
        d_we    = 0;
        if_addr = 32'h0000_0040;
        d_addr  = 32'h0000_0080;
        d_wdata = 32'h0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step();
        reset  = 0;
        stalls = 0;
        ifg    = 0;
        step();
        first_d = o_d_gnt;
        chk("t1_first_gnt_d", {31'b0, first_d}, 32'd1);
        if (o_if_stall) stalls++;
        if (o_if_gnt) ifg++;

        // Test 4: sustained contention gives D,D,D,D,IF
        for (int i = 0; i < 9; i++) begin
            step();
            if (o_if_stall) stalls++;
            if (o_if_gnt) ifg++;
        end
        chk("t4_if_stalls", stalls, 32'd8);
        chk("t4_if_grants", ifg, 32'd2);

        // Test 2: fetch-only stream
        d_req = 0;
        for (int i = 0; i < 3; i++) begin
            if_addr = i * 4;
            step();
        end
        if_req = 0;
        step();
        chk("t2_if_rdata_last", if_rdata, ref_mem[2]);
        if_req  = 1;
        if_addr = 32'h0;
        step();
        if_req = 0;
        step();
        chk("t2_if_rdata_0", if_rdata, 32'hEF200005);

        // Test 3: store then load same address
        d_req   = 1;
        d_we    = 1;
        d_addr  = 32'h10;
        d_wdata = 32'hDEADBEEF;
        step();
        chk("t3_store_we", {31'b0, o_mem_we}, 32'd1);
        d_we    = 0;
        d_wdata = 32'h0;
        step();
        chk("t3_load_we", {31'b0, o_mem_we}, 32'd0);
        d_req = 0;
        step();
        chk("t3_d_rvalid", {31'b0, o_d_rvalid}, 32'd1);
        chk("t3_d_rdata", d_rdata, 32'hDEADBEEF);

        // Test 5: reset right after a load grant drops the response
        if_req = 1;
        if_addr = 32'h20;
        d_req  = 1;
        d_addr = 32'h30;
        step();
        step();
        reset = 1;
        step();
        chk("t5_d_rvalid", {31'b0, o_d_rvalid}, 32'd0);
        reset = 0;
        ifg   = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (o_if_gnt) ifg++;
        end
        chk("t5_streak_cleared", ifg, 32'd0);
        step();
        chk("t5_if_after_4", {31'b0, o_if_gnt}, 32'd1);

        // Random traffic, requests held until granted
        for (int n = 0; n < 400; n++) begin
            if (!if_req || last_gi) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = $urandom;
            end
            if (!d_req || last_gd) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            reset = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 0;

`ifdef ARB_PERF_EN
        // Test 6: performance counters over 10 contended cycles
        reset  = 1;
        if_req = 0;
        d_req  = 0;
        step();
        reset = 0;
        if_req = 1;
        d_req  = 1;
        d_we   = 0;
        for (int i = 0; i < 10; i++) step();
        chk("t6_conflict", perf_conflict_cnt, 32'd10);
        chk("t6_if_stall", perf_if_stall_cnt, 32'd8);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
